// File: rtl/hazard_unit.sv
// Hazard detection and bypass control for the 5-stage pipeline.
// Keeps a private D->E->M->W tag pipeline of in-flight register writes.
module hazard_unit #(
  parameter int         CNT_W    = 16,
  parameter logic [4:0] ZERO_REG = 5'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic [1:0]       tuse_rs_D,
  input  logic [1:0]       tuse_rt_D,
  input  logic [4:0]       WA_D,
  input  logic             RegWrite_D,
  input  logic [1:0]       WDSrc_D,
  output logic             Stall_FD,
  output logic             DE_clr,
  output logic [1:0]       FwdA_D,
  output logic [1:0]       FwdB_D,
  output logic [1:0]       FwdA_E,
  output logic [1:0]       FwdB_E,
  output logic             FwdRt_M,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       rw_e, rw_m, rw_w;
  logic [4:0] wa_e, wa_m, wa_w;
  logic [1:0] tnew_e, tnew_m;
  logic [4:0] rs_e, rt_e, rt_m;
  logic [1:0] tnew_d;
  logic [1:0] rem_e, rem_m;
  logic       valid_e, valid_m, valid_w;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Reserved source 11 is treated like a load so it can only over-stall.
  always_comb begin
    tnew_d = 2'd3;
    case (WDSrc_D)
      2'b00:   tnew_d = 2'd2;
      2'b10:   tnew_d = 2'd1;
      default: tnew_d = 2'd3;
    endcase
  end

  // Cycles still needed before the producer's value exists; 0 = forwardable.
  assign rem_e   = dec_sat(tnew_e);
  assign rem_m   = dec_sat(tnew_m);
  assign valid_e = rw_e && (wa_e != ZERO_REG);
  assign valid_m = rw_m && (wa_m != ZERO_REG);
  assign valid_w = rw_w && (wa_w != ZERO_REG);

  function automatic logic op_stall(input logic [4:0] r, input logic [1:0] tuse);
    logic s;
    s = 1'b0;
    if (tuse != 2'd3) begin
      if (valid_e && (wa_e == r))      s = (rem_e > tuse);
      else if (valid_m && (wa_m == r)) s = (rem_m > tuse);
    end
    return s;
  endfunction

  // The youngest match decides; a match that is not ready yields 0 and relies on the stall.
  function automatic logic [1:0] fwd_d(input logic [4:0] r);
    logic [1:0] f;
    f = 2'd0;
    if (valid_e && (wa_e == r))      f = (rem_e == 2'd0) ? 2'd3 : 2'd0;
    else if (valid_m && (wa_m == r)) f = (rem_m == 2'd0) ? 2'd2 : 2'd0;
    else if (valid_w && (wa_w == r)) f = 2'd1;
    return f;
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] r);
    logic [1:0] f;
    f = 2'd0;
    if (valid_m && (wa_m == r))      f = (rem_m == 2'd0) ? 2'd2 : 2'd0;
    else if (valid_w && (wa_w == r)) f = 2'd1;
    return f;
  endfunction

  always_comb begin
    Stall_FD = op_stall(rs_D, tuse_rs_D) || op_stall(rt_D, tuse_rt_D);
    DE_clr   = Stall_FD;
    FwdA_D   = fwd_d(rs_D);
    FwdB_D   = fwd_d(rt_D);
    FwdA_E   = fwd_e(rs_e);
    FwdB_E   = fwd_e(rt_e);
    FwdRt_M  = valid_w && (wa_w == rt_m);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rw_e   <= 1'b0;
      wa_e   <= '0;
      tnew_e <= '0;
      rs_e   <= '0;
      rt_e   <= '0;
      rw_m   <= 1'b0;
      wa_m   <= '0;
      tnew_m <= '0;
      rt_m   <= '0;
      rw_w   <= 1'b0;
      wa_w   <= '0;
    end else begin
      if (DE_clr) begin
        rw_e   <= 1'b0;
        wa_e   <= '0;
        tnew_e <= '0;
        rs_e   <= '0;
        rt_e   <= '0;
      end else begin
        rw_e   <= RegWrite_D;
        wa_e   <= WA_D;
        tnew_e <= tnew_d;
        rs_e   <= rs_D;
        rt_e   <= rt_D;
      end
      rw_m   <= rw_e;
      wa_m   <= wa_e;
      tnew_m <= dec_sat(tnew_e);
      rt_m   <= rt_e;
      rw_w   <= rw_m;
      wa_w   <= wa_m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (Stall_FD && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer of the decoded control stream for the 5-stage pipeline (IF->D->E->M->W).
- Tracks in-flight register writes with its own D->E->M->W tag pipeline and generates the IF/D stall, the D/E bubble (DE_clr), forwarding selects for D, E and M, and a stall-cycle counter.
- Sits beside the datapath. It is the sole driver of the controller's DE_clr input and of all bypass-mux selects.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter
- ZERO_REG, 0, register index that never causes a hazard or a forward

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rs_D  in  5  source register A of the D-stage instruction
- rt_D  in  5  source register B of the D-stage instruction
- tuse_rs_D  in  2  cycles until rs is consumed: 0=D (branch/jr), 1=E (ALU), 2=M (store data), 3=unused
- tuse_rt_D  in  2  same encoding, for rt
- WA_D  in  5  resolved write address of the D-stage instruction
- RegWrite_D  in  1  D-stage instruction writes the GRF
- WDSrc_D  in  2  write-data source: 00=ALU, 01=Mem, 10=PC+8, 11=reserved (treated as Mem)
- Stall_FD  out  1  1 = hold PC and the F/D register
- DE_clr  out  1  1 = load a bubble into the D/E register next edge
- FwdA_D, FwdB_D  out  2 each  D-stage compare operands: 0=GRF, 1=W, 2=M, 3=E
- FwdA_E, FwdB_E  out  2 each  E-stage ALU operands: 0=GRF/D/E reg, 1=W, 2=M
- FwdRt_M  out  1  M-stage store data: 0=E/M reg, 1=W
- stall_cnt  out  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Tnew at D: ALU=2, Mem=3, PC+8=1. It decrements by 1 per stage advance and floors at 0. A stored Tnew of 0 means the value is forwardable from that stage.
- Internal tags: per stage E/M/W hold {RegWrite, WA, Tnew}. E and M also hold {rs, rt}, needed for the E and M forward selects.
- Tags advance every clock edge. The E tag loads from D inputs, or zeros when DE_clr=1.
- A producer is valid when RegWrite=1 and WA!=ZERO_REG.
- Stall (combinational) asserts when either operand, with tuse!=3, matches a valid producer in E or M whose Tnew > tuse.
  - The E stage is compared with Tnew_E-1 versus tuse.
  - The M stage is compared with Tnew_M-1 versus tuse.
- Priority: the youngest matching producer (E, then M, then W) decides the stall and the forward.
- DE_clr = Stall_FD, with identical timing. There is no other flush source.
- D forward select: E if the E tag matches and Tnew_E=0; else M if the M tag matches and Tnew_M=0; else W if the W tag matches; else 0.
  - A youngest match that is not yet ready yields 0. Stall covers this case.
- E forward select: uses rs_E/rt_E against the M tag (Tnew_M=0 required), then the W tag.
- FwdRt_M = 1 when rt_M matches a valid W tag.
- Forward outputs are combinational from tags and D inputs, and settle in the same cycle.
- stall_cnt increments on each edge where Stall_FD=1 and holds at all-ones.
- Reset (asynchronous, low) clears all tags and stall_cnt to 0.
  - Outputs immediately become Stall_FD=0, DE_clr=0, all Fwd=0.
  - Reset asserted mid-stall aborts the stall with no residual bubble.
- Reserved WDSrc=11 is treated as Mem (Tnew=3), so it is conservative.

Test Plan:
- lw $8 (WDSrc=01, WA=8), then add with rs=8, tuse_rs=1 -> Stall_FD=DE_clr=1 for exactly 1 cycle; next cycle FwdA_E=1 (W); stall_cnt=1.
- add $9, then beq with rs=9, tuse=0 -> 1 stall cycle (ALU in E, Tnew_E-1=1>0); then FwdA_D=2 (M); stall_cnt +1.
- lw $10, then sw with rt=10, tuse_rt=2 -> no stall; when sw reaches M, FwdRt_M=1.
- jal (WDSrc=10, WA=31), then jr with rs=31, tuse=0 -> no stall; FwdA_D=3 (E).
- Writes to $0 (WA=0, RegWrite=1) followed by a reader of $0 -> Stall_FD=0, all Fwd=0; add $5 twice back-to-back, then a reader of $5 -> forward selects the younger producer (M, value 2).
- Assert reset low while Stall_FD=1 -> Stall_FD, DE_clr, stall_cnt go 0 asynchronously. With CNT_W forced to 2 and 5 stalls applied, stall_cnt=3.
